// File: rtl/muldiv_sequencer.sv
// Iterative 32-cycle mult/multu/div/divu sequencer with architectural HI/LO registers.
// Optional macro MULDIV_DIV0_FAST_EN: divide-by-zero completes immediately and pulses div0.
module muldiv_sequencer #(
  parameter int ITERS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        div0
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opd_q, opd_d;
  logic          is_div_q, is_div_d;
  logic          a_neg_q, a_neg_d;
  logic          b_neg_q, b_neg_d;
  logic          div_zero_q, div_zero_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic        a_neg, b_neg, wr_ok, div_ge;
  logic [31:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] prod_fix;

`ifdef MULDIV_DIV0_FAST_EN
  logic div0_q, div0_d;
`endif

  always_comb begin
    a_neg     = ~op[0] & Read_data_1[31];
    b_neg     = ~op[0] & Read_data_2[31];
    a_mag     = a_neg ? (32'd0 - Read_data_1) : Read_data_1;
    b_mag     = b_neg ? (32'd0 - Read_data_2) : Read_data_2;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_trial = div_shift - {1'b0, opd_q};
    div_ge    = div_shift >= {1'b0, opd_q};
    prod_fix  = (a_neg_q ^ b_neg_q) ? (64'd0 - acc_q) : acc_q;
    quo_fix   = (a_neg_q ^ b_neg_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    // With a zero divisor the remainder ends up holding the dividend magnitude,
    // so re-applying the dividend sign reproduces the raw operand.
    rem_fix   = a_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    wr_ok     = ((state_q == IDLE) || (state_q == DONE)) && !start;

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
`ifdef MULDIV_DIV0_FAST_EN
    div0_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV0_FAST_EN
          if (op[1] && (Read_data_2 == 32'd0)) begin
            state_d = DONE;
            hi_d    = Read_data_1;
            lo_d    = 32'hFFFF_FFFF;
            div0_d  = 1'b1;
          end else
`endif
          begin
            state_d    = CALC;
            cnt_d      = '0;
            is_div_d   = op[1];
            a_neg_d    = a_neg;
            b_neg_d    = b_neg;
            div_zero_d = (Read_data_2 == 32'd0);
            opd_d      = op[1] ? b_mag : a_mag;
            acc_d      = {32'd0, (op[1] ? a_mag : b_mag)};
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_d = {(div_ge ? div_trial[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div_zero_q ? 32'hFFFF_FFFF : quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_ok) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      div0_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MULDIV_DIV0_FAST_EN
      div0_q     <= div0_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign stall = busy_q | (start & (state_q == IDLE));
`ifdef MULDIV_DIV0_FAST_EN
  assign div0  = div0_q;
`else
  assign div0  = 1'b0;
`endif

endmodule
